// File: rtl/cache_miss_ctrl_if.sv
// cache_miss_ctrl_if: CPU, line-array and memory bus bundle for cache_miss_ctrl.
// Ports: cpu_* load/store handshake, arr_* line array access, mem_* line transfer.
// Modports: slave = the controller, master = the surrounding CPU/array/memory.
interface cache_miss_ctrl_if #(parameter int ADDR_W = 32);
    logic              cpu_valid;
    logic              cpu_ready;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_done;
    logic [2:0]        arr_set;
    logic              arr_way;
    logic [255:0]      arr_rdata;
    logic              arr_we;
    logic [255:0]      arr_wdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [255:0]      mem_wdata;
    logic [255:0]      mem_rdata;
    logic              mem_ack;
    modport slave (
        input  cpu_valid, cpu_we, cpu_addr, cpu_wdata, arr_rdata, mem_rdata, mem_ack,
        output cpu_ready, cpu_rdata, cpu_done, arr_set, arr_way, arr_we, arr_wdata,
               mem_req, mem_we, mem_addr, mem_wdata
    );
    modport master (
        output cpu_valid, cpu_we, cpu_addr, cpu_wdata, arr_rdata, mem_rdata, mem_ack,
        input  cpu_ready, cpu_rdata, cpu_done, arr_set, arr_way, arr_we, arr_wdata,
               mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/cache_miss_ctrl.sv
// cache_miss_ctrl: blocking miss sequencer for a 2-way, 8-set, 256-bit-line data cache.
// Ports: clk, rst_n (sync, active-low), bus (cache_miss_ctrl_if.slave).
// Optional macro CACHE_STATS_EN adds hit_cnt/miss_cnt lookup counters.
module cache_miss_ctrl #(parameter int ADDR_W = 32) (
    input logic clk,
    input logic rst_n,
    cache_miss_ctrl_if.slave bus
`ifdef CACHE_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);
    localparam int TAG_W = ADDR_W - 8;
    typedef enum logic [2:0] {IDLE, LOOKUP, WB, REFILL, INSTALL, RESPOND} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-3:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              victim_q, victim_d;
    logic [255:0]      line_q, line_d;
    logic [TAG_W-1:0]  tag_q [8][2];
    logic [TAG_W-1:0]  tag_d [8][2];
    logic [7:0][1:0]   valid_q, valid_d, dirty_q, dirty_d;
    logic [7:0]        lru_q, lru_d;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;
    logic              cpu_done_q, cpu_done_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [255:0]      mem_wdata_q, mem_wdata_d;
    logic [TAG_W-1:0]  tag;
    logic [2:0]        set, word;
    logic              hit0, hit1, hit, hit_way, victim;
    logic [255:0]      base, merged;
    logic [31:0]       sel_word;
    logic              unused_addr;
    assign unused_addr = ^bus.cpu_addr[1:0];
    assign tag = addr_q[ADDR_W-3:6];
    assign set = addr_q[5:3];
    assign word = addr_q[2:0];
    assign hit0 = valid_q[set][0] && tag_q[set][0] == tag;
    assign hit1 = valid_q[set][1] && tag_q[set][1] == tag;
    assign hit = hit0 | hit1;
    assign hit_way = ~hit0;
    assign victim = !valid_q[set][0] ? 1'b0 : !valid_q[set][1] ? 1'b1 : lru_q[set];
    // The line being worked on comes from the array on a hit, from the refill buffer on install.
    assign base = (state_q == INSTALL) ? line_q : bus.arr_rdata;
    assign sel_word = base[{word, 5'b0} +: 32];
    always_comb begin
        merged = base;
        merged[{word, 5'b0} +: 32] = wdata_q;
    end
    assign bus.cpu_ready = state_q == IDLE;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.cpu_done = cpu_done_q;
    assign bus.arr_set = set;
    assign bus.arr_way = (state_q == LOOKUP) ? (hit ? hit_way : victim) : victim_q;
    assign bus.arr_we = (state_q == LOOKUP && hit && we_q) || state_q == INSTALL;
    assign bus.arr_wdata = (state_q == INSTALL && !we_q) ? line_q : merged;
    assign bus.mem_req = mem_req_q;
    assign bus.mem_we = mem_we_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        we_d = we_q;
        wdata_d = wdata_q;
        victim_d = victim_q;
        line_d = line_q;
        tag_d = tag_q;
        valid_d = valid_q;
        dirty_d = dirty_q;
        lru_d = lru_q;
        cpu_rdata_d = cpu_rdata_q;
        cpu_done_d = 1'b0;
        mem_req_d = mem_req_q;
        mem_we_d = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: if (bus.cpu_valid) begin
                addr_d = bus.cpu_addr[ADDR_W-1:2];
                we_d = bus.cpu_we;
                wdata_d = bus.cpu_wdata;
                state_d = LOOKUP;
            end
            LOOKUP: if (hit) begin
                cpu_rdata_d = we_q ? cpu_rdata_q : sel_word;
                dirty_d[set][hit_way] = dirty_q[set][hit_way] | we_q;
                lru_d[set] = ~hit_way;
                cpu_done_d = 1'b1;
                state_d = RESPOND;
            end else begin
                victim_d = victim;
                mem_req_d = 1'b1;
                // arr_way already points at the victim, so arr_rdata is the line to write back.
                if (valid_q[set][victim] && dirty_q[set][victim]) begin
                    mem_we_d = 1'b1;
                    mem_addr_d = {tag_q[set][victim], set, 5'b0};
                    mem_wdata_d = bus.arr_rdata;
                    state_d = WB;
                end else begin
                    mem_we_d = 1'b0;
                    mem_addr_d = {tag, set, 5'b0};
                    state_d = REFILL;
                end
            end
            WB: if (bus.mem_ack) begin
                mem_we_d = 1'b0;
                mem_addr_d = {tag, set, 5'b0};
                state_d = REFILL;
            end
            REFILL: if (bus.mem_ack) begin
                line_d = bus.mem_rdata;
                mem_req_d = 1'b0;
                state_d = INSTALL;
            end
            INSTALL: begin
                tag_d[set][victim_q] = tag;
                valid_d[set][victim_q] = 1'b1;
                dirty_d[set][victim_q] = we_q;
                lru_d[set] = ~victim_q;
                cpu_rdata_d = we_q ? cpu_rdata_q : sel_word;
                cpu_done_d = 1'b1;
                state_d = RESPOND;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        we_q <= we_d;
        wdata_q <= wdata_d;
        victim_q <= victim_d;
        line_q <= line_d;
        tag_q <= tag_d;
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= '0;
            dirty_q <= '0;
            lru_q <= '0;
            cpu_rdata_q <= '0;
            cpu_done_q <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q <= 1'b0;
            mem_addr_q <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            dirty_q <= dirty_d;
            lru_q <= lru_d;
            cpu_rdata_q <= cpu_rdata_d;
            cpu_done_q <= cpu_done_d;
            mem_req_q <= mem_req_d;
            mem_we_q <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end
`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
    assign hit_cnt_d = hit_cnt_q + {31'b0, state_q == LOOKUP && hit};
    assign miss_cnt_d = miss_cnt_q + {31'b0, state_q == LOOKUP && !hit};
    assign hit_cnt = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_q <= '0;
            miss_cnt_q <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end
`endif
endmodule

// File: tb/tb_cache_miss_ctrl.sv
// tb_cache_miss_ctrl: directed self-checking bench for cache_miss_ctrl with array and memory stubs.
module tb_cache_miss_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [255:0] arr [8][2];
    logic [255:0] l1, l1w, l2, l2w, l3, l4;
    cache_miss_ctrl_if #(.ADDR_W(32)) bus ();
`ifdef CACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;
`endif
    cache_miss_ctrl #(.ADDR_W(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
`ifdef CACHE_STATS_EN
        ,
        .hit_cnt(hit_cnt),
        .miss_cnt(miss_cnt)
`endif
    );
    always #5 clk = ~clk;
    assign bus.arr_rdata = arr[bus.arr_set][bus.arr_way];
    always @(posedge clk) if (bus.arr_we) arr[bus.arr_set][bus.arr_way] <= bus.arr_wdata;
    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask
    function automatic logic [255:0] mk_line(input logic [31:0] b);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = b + i;
        return l;
    endfunction
    // Presents one request in IDLE; returns at the negedge inside LOOKUP.
    task automatic start(input string t, input logic we, input logic [31:0] addr, input logic [31:0] wd, input logic way);
        check({t, "_ready"}, bus.cpu_ready, 1'b1);
        bus.cpu_valid = 1'b1;
        bus.cpu_we = we;
        bus.cpu_addr = addr;
        bus.cpu_wdata = wd;
        @(negedge clk);
        bus.cpu_valid = 1'b0;
        check({t, "_lk_way"}, bus.arr_way, way);
        check({t, "_lk_noreq"}, bus.mem_req, 1'b0);
    endtask
    task automatic hit(input string t, input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic way, input logic [255:0] exp_line, input logic [31:0] exp_rd);
        start(t, we, addr, wd, way);
        check({t, "_arr_we"}, bus.arr_we, we);
        if (we) check({t, "_arr_wdata"}, bus.arr_wdata, exp_line);
        @(negedge clk);
        check({t, "_done"}, bus.cpu_done, 1'b1);
        check({t, "_rdata"}, bus.cpu_rdata, exp_rd);
        check({t, "_noreq"}, bus.mem_req, 1'b0);
        @(negedge clk);
        check({t, "_done_pulse"}, bus.cpu_done, 1'b0);
    endtask
    // Entered at the first WB cycle; returns at the first REFILL cycle.
    task automatic wb(input string t, input logic [31:0] addr, input logic [255:0] data, input int delay);
        for (int i = 0; i <= delay; i++) begin
            check({t, "_wb_req"}, bus.mem_req, 1'b1);
            check({t, "_wb_we"}, bus.mem_we, 1'b1);
            check({t, "_wb_addr"}, bus.mem_addr, addr);
            check({t, "_wb_data"}, bus.mem_wdata, data);
            if (i == delay) bus.mem_ack = 1'b1;
            @(negedge clk);
        end
        bus.mem_ack = 1'b0;
    endtask
    // Entered at the first REFILL cycle; runs through install and the done pulse.
    task automatic refill(input string t, input logic [31:0] addr, input logic [255:0] mline,
                          input logic [255:0] iline, input logic way, input logic [31:0] exp_rd, input int delay);
        for (int i = 0; i <= delay; i++) begin
            check({t, "_rf_req"}, bus.mem_req, 1'b1);
            check({t, "_rf_we"}, bus.mem_we, 1'b0);
            check({t, "_rf_addr"}, bus.mem_addr, addr);
            if (i == delay) begin
                bus.mem_rdata = mline;
                bus.mem_ack = 1'b1;
            end
            @(negedge clk);
        end
        bus.mem_ack = 1'b0;
        bus.mem_rdata = '0;
        check({t, "_req_drop"}, bus.mem_req, 1'b0);
        check({t, "_inst_we"}, bus.arr_we, 1'b1);
        check({t, "_inst_way"}, bus.arr_way, way);
        check({t, "_inst_data"}, bus.arr_wdata, iline);
        check({t, "_done_early"}, bus.cpu_done, 1'b0);
        @(negedge clk);
        check({t, "_done"}, bus.cpu_done, 1'b1);
        check({t, "_rdata"}, bus.cpu_rdata, exp_rd);
        @(negedge clk);
        check({t, "_done_pulse"}, bus.cpu_done, 1'b0);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end
    initial begin
        for (int s = 0; s < 8; s++) for (int w = 0; w < 2; w++) arr[s][w] = '0;
        bus.cpu_valid = 1'b0;
        bus.cpu_we = 1'b0;
        bus.cpu_addr = '0;
        bus.cpu_wdata = '0;
        bus.mem_rdata = '0;
        bus.mem_ack = 1'b0;
        l1 = mk_line(32'h1000_0000);
        l1[63:32] = 32'hDEAD_BEEF;
        l1w = l1;
        l1w[95:64] = 32'h1234_5678;
        l2 = mk_line(32'h2000_0000);
        l2w = l2;
        l2w[63:32] = 32'hAABB_CCDD;
        l3 = mk_line(32'h3000_0000);
        l4 = mk_line(32'h4000_0000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_rdata", bus.cpu_rdata, 32'h0);
        check("rst_done", bus.cpu_done, 1'b0);
        check("rst_req", bus.mem_req, 1'b0);
        check("rst_we", bus.mem_we, 1'b0);
        check("rst_addr", bus.mem_addr, 32'h0);
        check("rst_wdata", bus.mem_wdata, 256'h0);
        check("rst_arr_we", bus.arr_we, 1'b0);
        // cold miss, earliest ack
        start("s1", 1'b0, 32'h0000_0104, 32'h0, 1'b0);
        @(negedge clk);
        refill("s1", 32'h0000_0100, l1, l1, 1'b0, 32'hDEAD_BEEF, 0);
        hit("s2", 1'b0, 32'h0000_0104, 32'h0, 1'b0, '0, 32'hDEAD_BEEF);
        hit("s3", 1'b1, 32'h0000_0108, 32'h1234_5678, 1'b0, l1w, 32'hDEAD_BEEF);
        // fill way1, delayed ack
        start("s4a", 1'b0, 32'h0000_0200, 32'h0, 1'b1);
        @(negedge clk);
        refill("s4a", 32'h0000_0200, l2, l2, 1'b1, 32'h2000_0000, 2);
        // dirty eviction of way0
        start("s4b", 1'b0, 32'h0000_0300, 32'h0, 1'b0);
        @(negedge clk);
        wb("s4b", 32'h0000_0100, l1w, 1);
        refill("s4b", 32'h0000_0300, l3, l3, 1'b0, 32'h3000_0000, 0);
`ifdef CACHE_STATS_EN
        check("stats_hit", hit_cnt, 32'd2);
        check("stats_miss", miss_cnt, 32'd3);
`endif
        // way0 most recently installed, so the next set0 miss evicts clean way1
        start("s4c", 1'b0, 32'h0000_0400, 32'h0, 1'b1);
        @(negedge clk);
        refill("s4c", 32'h0000_0400, l4, l4, 1'b1, 32'h4000_0000, 0);
        hit("s4d", 1'b0, 32'h0000_031C, 32'h0, 1'b0, '0, 32'h3000_0007);
        // reset during REFILL, then a late ack
        start("s5", 1'b0, 32'h0000_0104, 32'h0, 1'b1);
        @(negedge clk);
        check("s5_rf_req", bus.mem_req, 1'b1);
        rst_n = 1'b0;
        @(negedge clk);
        check("s5_rst_req", bus.mem_req, 1'b0);
        check("s5_rst_done", bus.cpu_done, 1'b0);
        rst_n = 1'b1;
        bus.mem_ack = 1'b1;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        check("s5_ready", bus.cpu_ready, 1'b1);
        check("s5_late_ack_req", bus.mem_req, 1'b0);
        check("s5_rdata_clr", bus.cpu_rdata, 32'h0);
        start("s5b", 1'b0, 32'h0000_0104, 32'h0, 1'b0);
        @(negedge clk);
        refill("s5b", 32'h0000_0100, l1, l1, 1'b0, 32'hDEAD_BEEF, 1);
        // write miss merges the word and leaves cpu_rdata alone
        start("s6", 1'b1, 32'h0000_0205, 32'hAABB_CCDD, 1'b1);
        @(negedge clk);
        refill("s6", 32'h0000_0200, l2, l2w, 1'b1, 32'hDEAD_BEEF, 0);
        // the written line is now dirty and gets written back
        hit("s7", 1'b0, 32'h0000_0104, 32'h0, 1'b0, '0, 32'hDEAD_BEEF);
        start("s8", 1'b0, 32'h0000_0500, 32'h0, 1'b1);
        @(negedge clk);
        wb("s8", 32'h0000_0200, l2w, 0);
        refill("s8", 32'h0000_0500, l4, l4, 1'b1, 32'h4000_0000, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
